// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: protocol state encoding and bus bit meanings.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      DEV_ADDR,
      DEV_ACK,
      REG_ADDR,
      REG_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } i2c_state_t;

   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one asynchronous bus line: 2-flop synchronizer, run-length glitch filter,
// and single-cycle rise/fall pulses aligned with the filtered level change.
module i2c_line_filter #(
   parameter int P_FILT = 3
) (
   input  logic i_local_clk,
   input  logic i_rst,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [1:0] sync;
   logic [3:0] run_cnt;
   logic       change;

   // The filtered level flips only on the P_FILT-th consecutive differing sample.
   assign change = (sync[1] != o_level) && (run_cnt == 4'(P_FILT - 1));

   always_ff @(posedge i_local_clk) begin
      if (i_rst) begin
         sync    <= 2'b11;
         run_cnt <= 4'd0;
         o_level <= 1'b1;
         o_rise  <= 1'b0;
         o_fall  <= 1'b0;
      end else begin
         sync   <= {sync[0], i_line};
         o_rise <= change & sync[1];
         o_fall <= change & ~sync[1];
         if (sync[1] == o_level) begin
            run_cnt <= 4'd0;
         end else if (change) begin
            o_level <= sync[1];
            run_cnt <= 4'd0;
         end else begin
            run_cnt <= run_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/i2c_slave.sv
// I2C register-access target: filtered START/STOP/bit decode, address match, auto-incrementing
// register pointer, and SDA updates delayed P_HOLD cycles after each filtered SCL fall.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] P_DEV_ADDR = 7'h50,
   parameter int         P_FILT     = 3,
   parameter int         P_HOLD     = 4
) (
   input  logic       i_local_clk,
   input  logic       i_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda,
   output logic       o_wr_en,
   output logic [7:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic       o_rd_req,
   output logic [7:0] o_rd_addr,
   input  logic [7:0] i_rd_data,
   output logic       o_busy,
   output logic       o_start_det,
   output logic       o_stop_det
);

   localparam logic [7:0] HOLD_CYCLES = 8'(P_HOLD);

   i2c_state_t state, state_next;
   logic       scl_f, scl_rise, scl_fall;
   logic       sda_f, sda_rise, sda_fall;
   logic       start_det, stop_det;
   logic [7:0] shift, ptr, hold_cnt;
   logic [2:0] bit_cnt;
   logic       byte_done, ack_bit, rd_load, drive_val;

   i2c_line_filter #(.P_FILT(P_FILT)) u_scl_filter (
      .i_local_clk(i_local_clk), .i_rst(i_rst), .i_line(i_scl),
      .o_level(scl_f), .o_rise(scl_rise), .o_fall(scl_fall)
   );

   i2c_line_filter #(.P_FILT(P_FILT)) u_sda_filter (
      .i_local_clk(i_local_clk), .i_rst(i_rst), .i_line(i_sda),
      .o_level(sda_f), .o_rise(sda_rise), .o_fall(sda_fall)
   );

   assign start_det = sda_fall & scl_f;
   assign stop_det  = sda_rise & scl_f;
   assign o_busy    = (state != IDLE) && (state != WAIT_STOP);

   always_ff @(posedge i_local_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   // Bit-level transitions happen on SCL falls, so each new state owns the whole following bit.
   always_comb begin
      state_next = state;
      drive_val  = 1'b1;
      if (start_det) begin
         state_next = DEV_ADDR;
      end else if (stop_det) begin
         state_next = IDLE;
      end else if (scl_fall) begin
         case (state)
            DEV_ADDR: if (byte_done) state_next = (shift[7:1] == P_DEV_ADDR) ? DEV_ACK : WAIT_STOP;
            DEV_ACK:  state_next = (shift[0] == RW_READ) ? RD_DATA : REG_ADDR;
            REG_ADDR: if (byte_done) state_next = REG_ACK;
            REG_ACK:  state_next = WR_DATA;
            WR_DATA:  if (byte_done) state_next = WR_ACK;
            WR_ACK:   state_next = WR_DATA;
            RD_DATA:  if (byte_done) state_next = RD_ACK;
            RD_ACK:   state_next = (ack_bit == ACK) ? RD_DATA : WAIT_STOP;
            default:  state_next = state;
         endcase
      end
      case (state)
         DEV_ACK, REG_ACK, WR_ACK: drive_val = ACK;
         RD_DATA:                  drive_val = shift[7];
         default:                  drive_val = 1'b1;
      endcase
   end

   always_ff @(posedge i_local_clk) begin
      if (i_rst) begin
         o_sda       <= 1'b1;
         o_wr_en     <= 1'b0;
         o_wr_addr   <= 8'h00;
         o_wr_data   <= 8'h00;
         o_rd_req    <= 1'b0;
         o_rd_addr   <= 8'h00;
         o_start_det <= 1'b0;
         o_stop_det  <= 1'b0;
         shift       <= 8'h00;
         ptr         <= 8'h00;
         hold_cnt    <= 8'h00;
         bit_cnt     <= 3'd0;
         byte_done   <= 1'b0;
         ack_bit     <= NACK;
         rd_load     <= 1'b0;
      end else begin
         o_wr_en     <= 1'b0;
         o_rd_req    <= 1'b0;
         o_start_det <= start_det;
         o_stop_det  <= stop_det;
         rd_load     <= o_rd_req;
         if (o_wr_en) ptr <= ptr + 8'd1;
         if (rd_load) shift <= i_rd_data;
         if (hold_cnt != 8'h00) hold_cnt <= hold_cnt - 8'd1;
         if (hold_cnt == 8'h01) o_sda <= drive_val;

         if (start_det || stop_det) begin
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            hold_cnt  <= 8'h00;
            o_sda     <= 1'b1;
         end else if (scl_rise) begin
            case (state)
               DEV_ADDR, REG_ADDR, WR_DATA: begin
                  shift     <= {shift[6:0], sda_f};
                  bit_cnt   <= bit_cnt + 3'd1;
                  byte_done <= (bit_cnt == 3'd7);
               end
               RD_DATA: begin
                  bit_cnt   <= bit_cnt + 3'd1;
                  byte_done <= (bit_cnt == 3'd7);
               end
               RD_ACK:  ack_bit <= sda_f;
               default: ;
            endcase
         end else if (scl_fall) begin
            hold_cnt <= HOLD_CYCLES;
            if (state_next != state) begin
               bit_cnt   <= 3'd0;
               byte_done <= 1'b0;
            end
            case (state)
               REG_ADDR: if (byte_done) ptr <= shift;
               WR_DATA: begin
                  if (byte_done) begin
                     o_wr_en   <= 1'b1;
                     o_wr_addr <= ptr;
                     o_wr_data <= shift;
                  end
               end
               RD_DATA: begin
                  if (byte_done) ptr <= ptr + 8'd1;
                  else           shift <= {shift[6:0], 1'b0};
               end
               default: ;
            endcase
            // Read data for the next byte is requested as soon as its first bit begins.
            if ((state_next == RD_DATA) && (state != RD_DATA)) begin
               o_rd_req  <= 1'b1;
               o_rd_addr <= ptr;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a timed bus-master model drives register transfers while a
// register-level model (pointer, expected strobes, expected read bytes) scores the DUT.
module tb_i2c_slave;

   localparam logic [6:0] DEV = 7'h50;
   localparam int         Q   = 14;

   logic       local_clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_drv, wr_en, rd_req, busy, start_det, stop_det;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

   int         n_checks = 0;
   int         n_pass = 0;
   int         start_cnt = 0;
   int         stop_cnt = 0;
   logic       low_seen = 1'b0;
   logic       prev_sda = 1'b1;
   logic       prev_rst = 1'b1;
   logic [15:0] wr_exp;
   logic [7:0]  rd_exp;
   logic [15:0] wr_q[$];
   logic [7:0]  rd_q[$];
   logic [7:0]  txn_data[4];
   logic [7:0]  rd_got[4];
   logic [7:0]  model_ptr = 8'h00;
   logic [7:0]  last_wr_addr, last_wr_data, last_rd_addr;

   assign sda_bus = sda_m & sda_drv;
   assign rd_data = ~rd_addr;

   always #5 local_clk = ~local_clk;

   i2c_slave #(.P_DEV_ADDR(DEV), .P_FILT(3), .P_HOLD(4)) dut (
      .i_local_clk(local_clk),
      .i_rst(rst),
      .i_scl(scl),
      .i_sda(sda_bus),
      .o_sda(sda_drv),
      .o_wr_en(wr_en),
      .o_wr_addr(wr_addr),
      .o_wr_data(wr_data),
      .o_rd_req(rd_req),
      .o_rd_addr(rd_addr),
      .i_rd_data(rd_data),
      .o_busy(busy),
      .o_start_det(start_det),
      .o_stop_det(stop_det)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
   endtask

   // Strobes are scored against the expected queues as they occur.
   always @(negedge local_clk) begin
      if (wr_en) begin
         if (wr_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL wr_unexpected: actual write 0x%0h<=0x%0h required none", wr_addr, wr_data);
         end else begin
            wr_exp = wr_q.pop_front();
            checkOutput("wr_addr", wr_addr, wr_exp[15:8]);
            checkOutput("wr_data", wr_data, wr_exp[7:0]);
         end
         last_wr_addr = wr_addr;
         last_wr_data = wr_data;
      end
      if (rd_req) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL rd_unexpected: actual read request 0x%0h required none", rd_addr);
         end else begin
            rd_exp = rd_q.pop_front();
            checkOutput("rd_addr", rd_addr, rd_exp);
         end
         last_rd_addr = rd_addr;
      end
      if (start_det || stop_det) checkOutput("start_stop_exclusive", start_det & stop_det, 0);
      if (start_det) start_cnt++;
      if (stop_det) stop_cnt++;
      if (sda_drv == 1'b0) low_seen = 1'b1;
      if ((sda_drv != prev_sda) && !prev_rst && !rst) checkOutput("sda_change_scl_low", scl, 0);
      prev_sda = sda_drv;
      prev_rst = rst;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge local_clk);
      #1;
   endtask

   task automatic do_bit(input logic b, output logic s);
      wait_cycles(Q); sda_m = b;
      wait_cycles(Q); scl = 1'b1;
      wait_cycles(Q); s = sda_bus;
      wait_cycles(Q); scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) do_bit(b[i], s);
      do_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic ack_out, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         do_bit(1'b1, s);
         b[i] = s;
      end
      do_bit(ack_out, s);
   endtask

   task automatic send_start();
      if (scl == 1'b0) begin
         wait_cycles(Q); sda_m = 1'b1;
         wait_cycles(Q); scl = 1'b1;
      end
      wait_cycles(Q); sda_m = 1'b0;
      wait_cycles(Q); scl = 1'b0;
   endtask

   task automatic send_stop();
      wait_cycles(Q); sda_m = 1'b0;
      wait_cycles(Q); scl = 1'b1;
      wait_cycles(Q); sda_m = 1'b1;
      wait_cycles(2 * Q);
   endtask

   // kind 0 = write, 1 = register read with repeated START, 2 = read from the current pointer.
   task automatic applyStimulus(input int kind, input logic [6:0] dev, input logic [7:0] reg_a, input int n);
      logic       ack;
      logic [7:0] b, exp_b;
      int         exp_starts;
      start_cnt  = 0;
      stop_cnt   = 0;
      low_seen   = 1'b0;
      exp_starts = 1;
      send_start();
      write_byte({dev, (kind == 2)}, ack);
      if (dev != DEV) begin
         checkOutput("dev_nack", ack, 1);
         checkOutput("busy_unaddressed", busy, 0);
         send_stop();
         checkOutput("sda_never_driven", low_seen, 0);
      end else begin
         checkOutput("dev_ack", ack, 0);
         checkOutput("busy_addressed", busy, 1);
         if (kind != 2) begin
            write_byte(reg_a, ack);
            checkOutput("reg_ack", ack, 0);
            model_ptr = reg_a;
         end
         if (kind == 0) begin
            for (int i = 0; i < n; i++) begin
               wr_q.push_back({model_ptr, txn_data[i]});
               write_byte(txn_data[i], ack);
               checkOutput("data_ack", ack, 0);
               model_ptr = model_ptr + 8'd1;
            end
         end else begin
            if (kind == 1) begin
               send_start();
               exp_starts = 2;
               write_byte({dev, 1'b1}, ack);
               checkOutput("rd_dev_ack", ack, 0);
            end
            for (int i = 0; i < n; i++) begin
               rd_q.push_back(model_ptr);
               read_byte(i == n - 1, b);
               rd_got[i] = b;
               exp_b = ~model_ptr;
               checkOutput("rd_byte", b, exp_b);
               model_ptr = model_ptr + 8'd1;
            end
            low_seen = 1'b0;
         end
         send_stop();
         if (kind != 0) checkOutput("released_after_nack", low_seen, 0);
      end
      checkOutput("start_count", start_cnt, exp_starts);
      checkOutput("stop_count", stop_cnt, 1);
      checkOutput("busy_after_stop", busy, 0);
      checkOutput("wr_pending", wr_q.size(), 0);
      checkOutput("rd_pending", rd_q.size(), 0);
   endtask

   task automatic glitch_test();
      start_cnt = 0;
      @(negedge local_clk); sda_m = 1'b0;
      @(negedge local_clk);
      @(negedge local_clk); sda_m = 1'b1;
      wait_cycles(20);
      checkOutput("glitch_no_start", start_cnt, 0);
      checkOutput("glitch_idle", busy, 0);
   endtask

   task automatic reset_mid_read();
      logic ack;
      send_start();
      write_byte({DEV, 1'b0}, ack);
      checkOutput("rst_dev_ack", ack, 0);
      write_byte(8'h80, ack);
      checkOutput("rst_reg_ack", ack, 0);
      send_start();
      write_byte({DEV, 1'b1}, ack);
      checkOutput("rst_rd_dev_ack", ack, 0);
      rd_q.push_back(8'h80);
      wait_cycles(Q); sda_m = 1'b1;
      wait_cycles(Q); scl = 1'b1;
      wait_cycles(Q);
      checkOutput("rd_drive_low", sda_drv, 0);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      checkOutput("rst_sda_released", sda_drv, 1);
      checkOutput("rst_idle", busy, 0);
      model_ptr = 8'h00;
      wait_cycles(2 * Q);
      checkOutput("rst_rd_pending", rd_q.size(), 0);
   endtask

   initial begin
      wait_cycles(5);
      rst = 1'b0;
      wait_cycles(2);
      checkOutput("reset_sda", sda_drv, 1);
      checkOutput("reset_wr_en", wr_en, 0);
      checkOutput("reset_rd_req", rd_req, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_wr_addr", wr_addr, 0);
      checkOutput("reset_wr_data", wr_data, 0);
      checkOutput("reset_rd_addr", rd_addr, 0);

      txn_data[0] = 8'hA5; txn_data[1] = 8'h5A;
      applyStimulus(0, DEV, 8'h10, 2);
      checkOutput("write_last_addr", last_wr_addr, 8'h11);
      checkOutput("write_last_data", last_wr_data, 8'h5A);

      applyStimulus(1, DEV, 8'h20, 3);
      checkOutput("read_byte0", rd_got[0], 8'hDF);
      checkOutput("read_byte1", rd_got[1], 8'hDE);
      checkOutput("read_byte2", rd_got[2], 8'hDD);
      checkOutput("read_last_addr", last_rd_addr, 8'h22);

      applyStimulus(0, 7'h51, 8'h10, 2);

      txn_data[0] = 8'h11; txn_data[1] = 8'h22;
      applyStimulus(0, DEV, 8'hFF, 2);
      checkOutput("wrap_last_addr", last_wr_addr, 8'h00);
      checkOutput("wrap_last_data", last_wr_data, 8'h22);

      glitch_test();

      reset_mid_read();
      applyStimulus(2, DEV, 8'h00, 2);
      checkOutput("ptr_after_reset", rd_got[0], 8'hFF);
      checkOutput("ptr_after_reset_next", last_rd_addr, 8'h01);

      for (int t = 0; t < 14; t++) begin
         int         kind;
         int         n;
         logic [6:0] dev;
         logic [7:0] reg_a;
         kind = $urandom_range(0, 2);
         dev  = DEV;
         if ($urandom_range(0, 6) == 0) begin
            dev = 7'($urandom_range(0, 127));
            if (dev == DEV) dev = DEV ^ 7'h01;
         end
         reg_a = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
         n     = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) txn_data[i] = 8'($urandom);
         applyStimulus(kind, dev, reg_a, n);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1500000;
      n_checks++;
      $display("[TB] FAIL watchdog: actual run still active, required completion");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
